// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle control unit plus ALU for the 8-bit,
// 4-register datapath. Fetches instruction bytes through a req/ack port,
// decodes them, reads operands from the external register bank and
// drives the bank's write port. Owns the PC and the Z/C flags.
//
// Memory handshake: imem_req is held high with imem_addr stable until a
// rising edge on which imem_ack is also high; that edge is the transfer
// (imem_data is consumed on it) and imem_req drops on the next cycle.
// imem_ack seen while imem_req is low is ignored.
module unidade_controle (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] imem_addr,
    output logic       imem_req,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    output logic [1:0] rf_sr1,
    output logic [1:0] rf_sr2,
    output logic [1:0] rf_dr,
    output logic       rf_write,
    output logic [7:0] rf_wrData,
    input  logic [7:0] rf_rdData1,
    input  logic [7:0] rf_rdData2,
    output logic       flag_z,
    output logic       flag_c,
    output logic       illegal,
    output logic       halted
);

    // FSM encoding
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_IMM    = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    // Opcodes (instruction bits [7:4])
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [2:0] state;
    logic [2:0] state_next;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [7:0] result;
    logic       z_q;
    logic       c_q;

    // Flags are computed in DECODE but only committed on the WB edge, so
    // they are parked here together with a "this op touches flags" bit.
    logic       flags_upd_q;
    logic       z_pend_q;
    logic       c_pend_q;

    logic [3:0] opcode;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [8:0] sum9;
    logic [7:0] alu_res;
    logic       alu_c;
    logic       alu_upd;
    logic       op_illegal;

    assign opcode     = ir[7:4];
    assign op_a       = rf_rdData1;
    assign op_b       = rf_rdData2;
    assign sum9       = {1'b0, op_a} + {1'b0, op_b};
    assign op_illegal = (opcode >= 4'hA) && (opcode <= 4'hE);

    // ALU: result, carry/borrow and whether the op updates Z/C
    always_comb begin
        alu_res = 8'h00;
        alu_c   = 1'b0;
        alu_upd = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res = sum9[7:0];
                alu_c   = sum9[8];
                alu_upd = 1'b1;
            end
            OP_SUB: begin
                alu_res = op_a - op_b;
                alu_c   = (op_a < op_b);
                alu_upd = 1'b1;
            end
            OP_AND: begin
                alu_res = op_a & op_b;
                alu_upd = 1'b1;
            end
            OP_OR: begin
                alu_res = op_a | op_b;
                alu_upd = 1'b1;
            end
            OP_XOR: begin
                alu_res = op_a ^ op_b;
                alu_upd = 1'b1;
            end
            OP_MOV: begin
                alu_res = op_b;
            end
            OP_NOT: begin
                alu_res = ~op_b;
                alu_upd = 1'b1;
            end
            OP_SHL: begin
                alu_res = {op_b[6:0], 1'b0};
                alu_c   = op_b[7];
                alu_upd = 1'b1;
            end
            default: begin
                alu_res = 8'h00;
            end
        endcase
    end

    // Next-state decision for the instruction sequencer
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (imem_ack) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OP_NOP)       state_next = S_FETCH;
                else if (opcode == OP_HALT) state_next = S_HALT;
                else if (opcode == OP_LDI)  state_next = S_IMM;
                else if (op_illegal)        state_next = S_FETCH;
                else                        state_next = S_WB;
            end
            S_IMM: begin
                if (imem_ack) state_next = S_WB;
            end
            S_WB: begin
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // PC, instruction and result registers; both byte fetches share the
    // same handshake and both advance the PC (wrapping at 0xFF)
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= 8'h00;
            ir     <= 8'h00;
            result <= 8'h00;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_data;
                        pc <= pc + 8'd1;
                    end
                end
                S_DECODE: begin
                    result <= alu_res;
                end
                S_IMM: begin
                    if (imem_ack) begin
                        result <= imem_data;
                        pc     <= pc + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Flag pipeline: capture in DECODE, commit on the write-back edge
    always_ff @(posedge clk) begin
        if (reset) begin
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            flags_upd_q <= 1'b0;
            z_pend_q    <= 1'b0;
            c_pend_q    <= 1'b0;
        end else begin
            if (state == S_DECODE) begin
                flags_upd_q <= alu_upd;
                z_pend_q    <= (alu_res == 8'h00);
                c_pend_q    <= alu_c;
            end
            if ((state == S_WB) && flags_upd_q) begin
                z_q <= z_pend_q;
                c_q <= c_pend_q;
            end
        end
    end

    // Outputs; control strobes are masked while reset is high so that a
    // reset landing in WB never produces a bank write
    assign imem_addr = pc;
    assign imem_req  = !reset && ((state == S_FETCH) || (state == S_IMM));
    assign rf_sr1    = ir[3:2];
    assign rf_sr2    = ir[1:0];
    assign rf_dr     = ir[3:2];
    assign rf_wrData = result;
    assign rf_write  = !reset && (state == S_WB);
    assign illegal   = !reset && (state == S_DECODE) && op_illegal;
    assign halted    = !reset && (state == S_HALT);
    assign flag_z    = z_q;
    assign flag_c    = c_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: instruction memory with
// programmable ack latency, a 4x8 register bank model and a write log
// checked against an expected-write queue.
module tb_unidade_controle;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] imem_addr;
    logic       imem_req;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [1:0] rf_sr1;
    logic [1:0] rf_sr2;
    logic [1:0] rf_dr;
    logic       rf_write;
    logic [7:0] rf_wrData;
    logic [7:0] rf_rdData1;
    logic [7:0] rf_rdData2;
    logic       flag_z;
    logic       flag_c;
    logic       illegal;
    logic       halted;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [256];
    logic [7:0] regs [4] = '{default: 8'h00};
    logic [9:0] wr_q [$];
    logic [9:0] exp_q [$];

    int   ack_delay = 0;
    int   wait_cnt = 0;
    logic ack_force_en = 1'b0;
    logic ack_force_val = 1'b0;

    unidade_controle dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .rf_sr1     (rf_sr1),
        .rf_sr2     (rf_sr2),
        .rf_dr      (rf_dr),
        .rf_write   (rf_write),
        .rf_wrData  (rf_wrData),
        .rf_rdData1 (rf_rdData1),
        .rf_rdData2 (rf_rdData2),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .illegal    (illegal),
        .halted     (halted)
    );

    // clock / reset
    always #5 clk = ~clk;

    // memory and bank models
    assign imem_data  = mem[imem_addr];
    assign imem_ack   = ack_force_en ? ack_force_val
                                     : (imem_req && (wait_cnt == ack_delay));
    assign rf_rdData1 = regs[rf_sr1];
    assign rf_rdData2 = regs[rf_sr2];

    always @(posedge clk) begin
        if (reset || !imem_req || imem_ack) wait_cnt <= 0;
        else                                wait_cnt <= wait_cnt + 1;
    end

    always @(posedge clk) begin
        if (rf_write) begin
            regs[rf_dr] <= rf_wrData;
            wr_q.push_back({rf_dr, rf_wrData});
        end
    end

    // driver / checker tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic exp_wr(input logic [1:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic check_writes(input string tag);
        logic [9:0] o;
        logic [9:0] e;
        chk({tag, "_count"}, 16'(wr_q.size()), 16'(exp_q.size()));
        while ((wr_q.size() > 0) && (exp_q.size() > 0)) begin
            o = wr_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_data"}, {6'h0, o}, {6'h0, e});
        end
        wr_q.delete();
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        // LDI R1,05; LDI R2,FB; ADD R1,R2
        mem[0] = 8'h74; mem[1] = 8'h05; mem[2] = 8'h78; mem[3] = 8'hFB; mem[4] = 8'h16;
        // LDI R0,03; LDI R3,04; SUB R0,R3; MOV R2,R0
        mem[5] = 8'h70; mem[6] = 8'h03; mem[7] = 8'h7C; mem[8] = 8'h04;
        mem[9] = 8'h23; mem[10] = 8'h68;
        // illegal opcode
        mem[11] = 8'hA0;
        // repeat of the first program, run with slow memory
        mem[12] = 8'h74; mem[13] = 8'h05; mem[14] = 8'h78; mem[15] = 8'hFB; mem[16] = 8'h16;
        // HALT
        mem[17] = 8'hF0;

        tick();
        tick();
        chk("rst_req", 16'(imem_req), 16'h0);
        chk("rst_write", 16'(rf_write), 16'h0);
        chk("rst_halted", 16'(halted), 16'h0);
        chk("rst_illegal", 16'(illegal), 16'h0);
        chk("rst_addr", 16'(imem_addr), 16'h00);
        chk("rst_z", 16'(flag_z), 16'h0);
        chk("rst_c", 16'(flag_c), 16'h0);

        reset = 1'b0;
        #1;
        chk("first_req", 16'(imem_req), 16'h1);
        chk("first_addr", 16'(imem_addr), 16'h00);

        // program 1, zero-wait memory: 11 cycles
        repeat (10) tick();
        chk("p1_wb_write", 16'(rf_write), 16'h1);
        chk("p1_wb_dr", 16'(rf_dr), 16'h1);
        chk("p1_wb_data", 16'(rf_wrData), 16'h00);
        chk("p1_wb_req", 16'(imem_req), 16'h0);
        tick();
        chk("p1_pc", 16'(imem_addr), 16'h05);
        chk("p1_z", 16'(flag_z), 16'h1);
        chk("p1_c", 16'(flag_c), 16'h1);
        chk("p1_r1", 16'(regs[1]), 16'h00);
        chk("p1_r2", 16'(regs[2]), 16'hFB);
        exp_wr(2'd1, 8'h05); exp_wr(2'd2, 8'hFB); exp_wr(2'd1, 8'h00);
        check_writes("p1_wr");

        // program 2: two LDIs keep flags, SUB sets borrow, MOV keeps flags
        repeat (8) tick();
        chk("p2_ldi_z", 16'(flag_z), 16'h1);
        chk("p2_ldi_c", 16'(flag_c), 16'h1);
        chk("p2_r0", 16'(regs[0]), 16'h03);
        chk("p2_r3", 16'(regs[3]), 16'h04);
        repeat (3) tick();
        chk("p2_sub_r0", 16'(regs[0]), 16'hFF);
        chk("p2_sub_z", 16'(flag_z), 16'h0);
        chk("p2_sub_c", 16'(flag_c), 16'h1);
        chk("p2_sub_pc", 16'(imem_addr), 16'h0A);
        repeat (3) tick();
        chk("p2_mov_r2", 16'(regs[2]), 16'hFF);
        chk("p2_mov_z", 16'(flag_z), 16'h0);
        chk("p2_mov_c", 16'(flag_c), 16'h1);
        chk("p2_mov_pc", 16'(imem_addr), 16'h0B);
        exp_wr(2'd0, 8'h03); exp_wr(2'd3, 8'h04); exp_wr(2'd0, 8'hFF); exp_wr(2'd2, 8'hFF);
        check_writes("p2_wr");

        // illegal opcode: one-cycle pulse, no write, pc advanced
        tick();
        chk("ill_pulse", 16'(illegal), 16'h1);
        chk("ill_write", 16'(rf_write), 16'h0);
        chk("ill_pc", 16'(imem_addr), 16'h0C);
        tick();
        chk("ill_clear", 16'(illegal), 16'h0);
        chk("ill_refetch", 16'(imem_req), 16'h1);
        chk("ill_addr", 16'(imem_addr), 16'h0C);
        check_writes("ill_wr");

        // slow memory: 3 wait cycles per fetch
        ack_delay = 3;
        for (int i = 0; i < 4; i++) begin
            chk("slow_req_held", 16'(imem_req), 16'h1);
            chk("slow_addr_held", 16'(imem_addr), 16'h0C);
            tick();
        end
        chk("slow_req_drop", 16'(imem_req), 16'h0);
        repeat (22) tick();
        chk("slow_pc", 16'(imem_addr), 16'h11);
        chk("slow_z", 16'(flag_z), 16'h1);
        chk("slow_c", 16'(flag_c), 16'h1);
        chk("slow_r1", 16'(regs[1]), 16'h00);
        chk("slow_r2", 16'(regs[2]), 16'hFB);
        exp_wr(2'd1, 8'h05); exp_wr(2'd2, 8'hFB); exp_wr(2'd1, 8'h00);
        check_writes("slow_wr");

        // HALT: no requests or writes whatever imem_ack does
        ack_delay = 0;
        tick();
        chk("halt_decode", 16'(halted), 16'h0);
        tick();
        chk("halt_on", 16'(halted), 16'h1);
        ack_force_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ack_force_val = i[0];
            #1;
            chk("halt_req", 16'(imem_req), 16'h0);
            chk("halt_write", 16'(rf_write), 16'h0);
            chk("halt_hold", 16'(halted), 16'h1);
            tick();
        end
        ack_force_en = 1'b0;
        chk("halt_pc", 16'(imem_addr), 16'h12);
        check_writes("halt_wr");

        // reset out of HALT, then ADD R2,R2 twice, second cut off in WB
        reset = 1'b1;
        #1;
        chk("hrst_halted", 16'(halted), 16'h0);
        chk("hrst_req", 16'(imem_req), 16'h0);
        mem[0] = 8'h1A;
        mem[1] = 8'h1A;
        tick();
        reset = 1'b0;
        #1;
        chk("hrst_pc", 16'(imem_addr), 16'h00);
        chk("hrst_req_up", 16'(imem_req), 16'h1);
        chk("hrst_z", 16'(flag_z), 16'h0);
        chk("hrst_c", 16'(flag_c), 16'h0);
        repeat (3) tick();
        chk("dbl_r2", 16'(regs[2]), 16'hF6);
        chk("dbl_z", 16'(flag_z), 16'h0);
        chk("dbl_c", 16'(flag_c), 16'h1);
        repeat (2) tick();
        chk("wbrst_pre_write", 16'(rf_write), 16'h1);
        chk("wbrst_pre_data", 16'(rf_wrData), 16'hEC);
        reset = 1'b1;
        #1;
        chk("wbrst_write", 16'(rf_write), 16'h0);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0]   = 8'h0C;
        mem[255] = 8'h74;
        tick();
        reset = 1'b0;
        #1;
        chk("wbrst_pc", 16'(imem_addr), 16'h00);
        chk("wbrst_z", 16'(flag_z), 16'h0);
        chk("wbrst_c", 16'(flag_c), 16'h0);
        chk("wbrst_r2", 16'(regs[2]), 16'hF6);
        exp_wr(2'd2, 8'hF6);
        check_writes("wbrst_wr");

        // 255 NOPs bring pc to 0xFF; LDI there takes its immediate from 0x00
        repeat (510) tick();
        chk("wrap_pc_ff", 16'(imem_addr), 16'hFF);
        chk("wrap_req", 16'(imem_req), 16'h1);
        tick();
        chk("wrap_pc_00", 16'(imem_addr), 16'h00);
        tick();
        chk("wrap_imm_req", 16'(imem_req), 16'h1);
        chk("wrap_imm_addr", 16'(imem_addr), 16'h00);
        tick();
        chk("wrap_wb_write", 16'(rf_write), 16'h1);
        chk("wrap_wb_dr", 16'(rf_dr), 16'h1);
        chk("wrap_wb_data", 16'(rf_wrData), 16'h0C);
        chk("wrap_wb_pc", 16'(imem_addr), 16'h01);
        tick();
        chk("wrap_r1", 16'(regs[1]), 16'h0C);
        chk("wrap_next_req", 16'(imem_req), 16'h1);
        exp_wr(2'd1, 8'h0C);
        check_writes("wrap_wr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multi-cycle control unit and ALU for the 8-bit, 4-register datapath. Fetches instruction bytes over a req/ack memory handshake, decodes them, reads operands from the 4x8 register bank, computes the result, and drives the bank's write port (sr1/sr2/dr/write/wrData). It is the initiator side of the register-bank interface and owns the PC and the Z/C flags.

## Interface
- No parameters; data width 8, register address width 2.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_addr  out  8  fetch address (= pc)
- imem_req  out  1  fetch request
- imem_ack  in  1  memory accepts request; imem_data valid this cycle
- imem_data  in  8  instruction/immediate byte
- rf_sr1  out  2  bank read address 1 (= ir[3:2])
- rf_sr2  out  2  bank read address 2 (= ir[1:0])
- rf_dr  out  2  bank write address (= ir[3:2])
- rf_write  out  1  bank write enable, one-cycle pulse
- rf_wrData  out  8  bank write data (= result register)
- rf_rdData1  in  8  combinational read of rf_sr1
- rf_rdData2  in  8  combinational read of rf_sr2
- flag_z  out  1  zero flag
- flag_c  out  1  carry/borrow flag
- illegal  out  1  one-cycle pulse on undefined opcode
- halted  out  1  high in HALT state

## Operation
- Instruction byte: [7:4] opcode, [3:2] ra (dest and src1), [1:0] rb (src2).
- Opcodes: 0 NOP; 1 ADD ra=ra+rb; 2 SUB ra=ra-rb; 3 AND; 4 OR; 5 XOR; 6 MOV ra=rb; 7 LDI ra=next byte; 8 NOT ra=~rb; 9 SHL ra=rb<<1; F HALT; A-E illegal.
- States: FETCH, DECODE, IMM, WB, HALT.
- FETCH: imem_req=1, imem_addr=pc. On edge with imem_ack=1: ir<=imem_data, pc<=pc+1, ->DECODE. Otherwise hold.
- DECODE: operands from rf_rdData1/2 (ir-driven addresses); result<=ALU output. Next: NOP->FETCH; illegal->FETCH with illegal=1 this cycle; HALT->HALT; LDI->IMM; others->WB.
- IMM: same handshake as FETCH; on ack result<=imem_data, pc<=pc+1, ->WB.
- WB: rf_write=1, rf_dr=ra, rf_wrData=result; flags update on same edge; ->FETCH.
- HALT: halted=1, no requests, no writes; exit only by reset.
- Arithmetic 8-bit, wraps. ADD: C=carry out bit 8. SUB: C=1 iff ra<rb (unsigned borrow). SHL: C=rb[7]. AND/OR/XOR/NOT: C=0. Z=(result==0) for ops 1-5,8,9. MOV and LDI leave Z/C unchanged.
- pc wraps 0xFF->0x00, including on an immediate fetch.

## Timing
- Reset (while high, and state after): pc=0, ir=0, result=0, Z=0, C=0, state=FETCH; imem_req, rf_write, illegal, halted forced 0 during reset cycles. First imem_req in first cycle after reset drops.
- imem_req stays high until the ack edge; imem_addr stable throughout; deasserts the cycle after ack. imem_ack while imem_req=0 ignored.
- ALU op with zero-wait memory: 3 cycles (FETCH, DECODE, WB). LDI: 4 cycles. NOP/illegal: 2 cycles. Each memory wait cycle adds 1.
- rf_write high exactly one cycle per writing instruction; written value visible to the next DECODE via bank read.
- Reset asserted mid-instruction (any state, incl. WB): no write on that edge; state as above next cycle.
- ra==rb legal (e.g. ADD R1,R1 doubles R1).

## Test plan
- Reset, program LDI R1,0x05; LDI R2,0xFB; ADD R1,R2 (bytes 74 05 78 FB 16), ack same cycle -> writes R1=05, R2=FB, R1=00; Z=1, C=1; pc=5 after 11 cycles.
- SUB R0,R3 with R0=0x03, R3=0x04 -> R0=0xFF, Z=0, C=1; then MOV R2,R0 -> R2=0xFF, flags unchanged.
- imem_ack delayed 3 cycles per fetch -> imem_req/imem_addr held stable 4 cycles each; results identical to zero-wait run.
- Byte 0xA0 -> illegal pulses 1 cycle in DECODE, no rf_write, pc advances by 1, next fetch proceeds.
- Byte 0xF0 -> halted=1, imem_req=0 for 20 cycles despite ack toggling; reset -> pc=0, halted=0, fetch restarts.
- Reset asserted in WB of an ADD -> rf_write=0 that edge; pc=0, Z=C=0 next cycle; LDI at pc=0xFF fetches immediate from 0x00.
